// File: rtl/regfl_wrarb.sv
// regfl_wrarb: write-port controller in front of the 8 x W register file.
//
// After reset, the block clears every register: it writes zero to s = 0..2**A-1
// on consecutive edges. It then shares the single write port between N
// requesters through a registered round-robin arbiter. Each grant raises a
// one-cycle, one-hot acknowledge at the same time as the write.
//
// Ports:
//   clk        rising-edge clock
//   rst_b      asynchronous active-low reset
//   req        [N]    per-requester write request, held until acknowledged
//   addr       [N*A]  requester i address in bits [i*A +: A]
//   data       [N*W]  requester i data in bits [i*W +: W]
//   ack        [N]    one-hot, one-cycle pulse: request was issued
//   we         register file write enable (registered)
//   s          [A]    register file select (registered)
//   d          [W]    register file write data (registered)
//   init_done  high once the clear sequence has finished issuing
module regfl_wrarb #(
    parameter int N = 4,
    parameter int W = 64,
    parameter int A = 3
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic [N-1:0]   req,
    input  logic [N*A-1:0] addr,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]   ack,
    output logic           we,
    output logic [A-1:0]   s,
    output logic [W-1:0]   d,
    output logic           init_done
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [A-1:0]   cnt, cnt_nx;
    logic [PW-1:0]  ptr, ptr_nx;
    logic [N-1:0]   ack_nx;
    logic           we_nx;
    logic [A-1:0]   s_nx;
    logic [W-1:0]   d_nx;
    logic           init_done_nx;

    logic [N-1:0]   elig;
    logic           found;
    logic [PW-1:0]  win;

    // A requester acknowledged this cycle is still retiring its request, so
    // it is masked out to avoid issuing the same write twice.
    always_comb begin
        elig  = req & ~ack;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        ptr_nx       = ptr;
        ack_nx       = '0;
        we_nx        = 1'b0;
        s_nx         = s;
        d_nx         = d;
        init_done_nx = init_done;

        case (state)
            ST_INIT: begin
                we_nx  = 1'b1;
                s_nx   = cnt;
                d_nx   = '0;
                cnt_nx = cnt + 1'b1;
                if (cnt == {A{1'b1}}) begin
                    state_nx     = ST_ARB;
                    init_done_nx = 1'b1;
                end
            end
            ST_ARB: begin
                if (found) begin
                    we_nx       = 1'b1;
                    s_nx        = addr[int'(win)*A +: A];
                    d_nx        = data[int'(win)*W +: W];
                    ack_nx[win] = 1'b1;
                    if (int'(win) == N - 1) ptr_nx = '0;
                    else                    ptr_nx = win + 1'b1;
                end
            end
            default: begin
                state_nx = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ST_INIT;
            cnt       <= '0;
            ptr       <= '0;
            ack       <= '0;
            we        <= 1'b0;
            s         <= '0;
            d         <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ptr       <= ptr_nx;
            ack       <= ack_nx;
            we        <= we_nx;
            s         <= s_nx;
            d         <= d_nx;
            init_done <= init_done_nx;
        end
    end

endmodule

// File: tb/tb_regfl_wrarb.sv
// Directed testbench for regfl_wrarb (N=4, W=64, A=3). A behavioural
// register file captures the DUT write port, so register contents can be checked.
module tb_regfl_wrarb;

    localparam int N = 4;
    localparam int W = 64;
    localparam int A = 3;

    logic           clk;
    logic           rst_b;
    logic [N-1:0]   req;
    logic [N*A-1:0] addr;
    logic [N*W-1:0] data;
    logic [N-1:0]   ack;
    logic           we;
    logic [A-1:0]   s;
    logic [W-1:0]   d;
    logic           init_done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] rf [8];

    regfl_wrarb #(.N(N), .W(W), .A(A)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req       (req),
        .addr      (addr),
        .data      (data),
        .ack       (ack),
        .we        (we),
        .s         (s),
        .d         (d),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    end

    always @(posedge clk) begin
        if (we) rf[s] <= d;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [A-1:0] a, input logic [W-1:0] v);
        addr[i*A +: A] = a;
        data[i*W +: W] = v;
    endtask

    task automatic check_port(input string tag, input logic ewe, input logic [N-1:0] eack);
        check({tag, "_we"}, 64'(we), 64'(ewe));
        check({tag, "_ack"}, 64'(ack), 64'(eack));
    endtask

    task automatic run_clear(input string tag);
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("%s_e%0d_we", tag, e), 64'(we), 64'd1);
            check($sformatf("%s_e%0d_s", tag, e), 64'(s), 64'(e - 1));
            check($sformatf("%s_e%0d_d", tag, e), d, 64'd0);
            check($sformatf("%s_e%0d_ack", tag, e), 64'(ack), 64'd0);
            check($sformatf("%s_e%0d_done", tag, e), 64'(init_done), (e == 8) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        rst_b = 1'b0;
        req   = '0;
        addr  = '0;
        data  = '0;

        // Reset state
        #12;
        check("rst_we", 64'(we), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_d", d, 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_done", 64'(init_done), 64'd0);

        // Clear sequence, then idle arbitration
        @(negedge clk);
        rst_b = 1'b1;
        run_clear("clr");
        step();
        check_port("idle9", 1'b0, 4'b0000);
        check("idle9_done", 64'(init_done), 64'd1);
        for (int i = 0; i < 8; i++) check($sformatf("rf%0d_clear", i), rf[i], 64'd0);

        // Single request from requester 2
        set_req(2, 3'd5, 64'hDEAD_BEEF);
        req = 4'b0100;
        step();
        check_port("r2", 1'b1, 4'b0100);
        check("r2_s", 64'(s), 64'd5);
        check("r2_d", d, 64'hDEAD_BEEF);
        req = 4'b0000;
        step();
        check_port("r2_after", 1'b0, 4'b0000);
        check("r2_s_hold", 64'(s), 64'd5);
        check("rf5", rf[5], 64'hDEAD_BEEF);

        // ptr=3 with requesters 0 and 3: 3 wins, then 0
        set_req(0, 3'd1, 64'h0000_0000_0000_00A0);
        set_req(3, 3'd2, 64'h0000_0000_0000_00A3);
        req = 4'b1001;
        step();
        check_port("wrap_g3", 1'b1, 4'b1000);
        check("wrap_g3_s", 64'(s), 64'd2);
        req = 4'b0001;
        step();
        check_port("wrap_g0", 1'b1, 4'b0001);
        check("wrap_g0_d", d, 64'hA0);
        req = 4'b0000;
        step();
        check_port("wrap_idle", 1'b0, 4'b0000);
        check("rf2", rf[2], 64'hA3);
        check("rf1", rf[1], 64'hA0);

        // ptr is 1 now; a single grant to 3 returns it to 0
        set_req(3, 3'd3, 64'h33);
        req = 4'b1000;
        step();
        check_port("p0_g3", 1'b1, 4'b1000);
        req = 4'b0000;
        step();
        check_port("p0_idle", 1'b0, 4'b0000);

        // All four requesting, ptr=0: grants 0,1,2,3
        for (int i = 0; i < N; i++) set_req(i, 3'(i + 4), 64'h1000 + 64'(i));
        req = 4'b1111;
        for (int g = 0; g < N; g++) begin
            step();
            check_port($sformatf("all_g%0d", g), 1'b1, 4'(1 << g));
            check($sformatf("all_g%0d_s", g), 64'(s), 64'(g + 4));
            check($sformatf("all_g%0d_d", g), d, 64'h1000 + 64'(g));
            req[g] = 1'b0;
        end
        step();
        check_port("all_idle", 1'b0, 4'b0000);

        // Requester 1 re-requests after each ack, 3 always requesting
        set_req(1, 3'd6, 64'h11);
        set_req(3, 3'd7, 64'h33);
        req = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            step();
            check_port($sformatf("alt_g%0d", g), 1'b1, (g % 2 == 0) ? 4'b0010 : 4'b1000);
            if (g % 2 == 0) set_req(1, 3'd6, 64'h11 + 64'(g + 1));
        end
        req = 4'b0000;
        step();
        check_port("alt_idle", 1'b0, 4'b0000);

        // Reset during an active ack; request stays held
        set_req(2, 3'd4, 64'hCAFE);
        req = 4'b0100;
        step();
        check_port("ra_pre", 1'b1, 4'b0100);
        rst_b = 1'b0;
        #1;
        check_port("ra_async", 1'b0, 4'b0000);
        check("ra_async_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // Reset again at edge 4 of the clear sequence
        for (int e = 1; e <= 4; e++) step();
        check("ri_e4_s", 64'(s), 64'd3);
        rst_b = 1'b0;
        #1;
        check("ri_async_we", 64'(we), 64'd0);
        check("ri_async_s", 64'(s), 64'd0);
        check("ri_async_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        run_clear("clr2");

        // Held request issued on edge 9
        step();
        check_port("held_g2", 1'b1, 4'b0100);
        check("held_g2_s", 64'(s), 64'd4);
        check("held_g2_d", d, 64'hCAFE);
        req = 4'b0000;
        step();
        check_port("held_idle", 1'b0, 4'b0000);
        check("rf4", rf[4], 64'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
